// File: rtl/pulse_gen.sv
// Programmable pulse-train generator: IDLE/PULSE/GAP sequencer timed by a S x 10^tb prescaler.
// Optional PULSE_GEN_EXT_START_EN adds a synchronized, edge-detected ext_start input.
module pulse_gen (
    input  logic       clk,
    input  logic       rst_sync,
    input  logic       start,
    input  logic       abort,
    input  logic       cfg_positive,
    input  logic [7:0] cfg_width,
    input  logic [7:0] cfg_gap,
    input  logic [7:0] cfg_num_pulses,
    input  logic [4:0] cfg_stage1_count,
    input  logic [2:0] cfg_time_base,
`ifdef PULSE_GEN_EXT_START_EN
    input  logic       ext_start,
`endif
    output logic       pulse_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

    state_e      state_q, state_d;
    logic        pulse_out_d, done_d;
    logic [4:0]  stage1_q;
    logic [23:0] decade_q;
    logic [7:0]  phase_q;
    logic [7:0]  pulse_cnt_q;

    logic        positive_q;
    logic [7:0]  width_q, gap_q, num_q;
    logic [4:0]  stage1_lim_q;
    logic [23:0] decade_lim_q;

    logic        start_req, start_ok;
    logic        stage1_wrap, unit_tick, phase_end, last_pulse;
    logic [7:0]  phase_len;

    function automatic logic [23:0] decade_limit(input logic [2:0] tb);
        case (tb)
            3'd0:    decade_limit = 24'd1;
            3'd1:    decade_limit = 24'd10;
            3'd2:    decade_limit = 24'd100;
            3'd3:    decade_limit = 24'd1000;
            3'd4:    decade_limit = 24'd10000;
            3'd5:    decade_limit = 24'd100000;
            3'd6:    decade_limit = 24'd1000000;
            default: decade_limit = 24'd10000000;
        endcase
    endfunction

`ifdef PULSE_GEN_EXT_START_EN
    logic ext_sync1_q, ext_sync2_q, ext_prev_q;

    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            ext_sync1_q <= 1'b0;
            ext_sync2_q <= 1'b0;
            ext_prev_q  <= 1'b0;
        end else begin
            ext_sync1_q <= ext_start;
            ext_sync2_q <= ext_sync1_q;
            ext_prev_q  <= ext_sync2_q;
        end
    end

    assign start_req = start | (ext_sync2_q & ~ext_prev_q);
`else
    assign start_req = start;
`endif

    // A start landing on the done cycle is dropped; abort always wins.
    assign start_ok    = start_req && !abort && !done;
    assign stage1_wrap = (stage1_q == stage1_lim_q - 5'd1);
    assign unit_tick   = stage1_wrap && (decade_q == decade_lim_q - 24'd1);
    assign phase_len   = (state_q == StPulse) ? width_q : gap_q;
    assign phase_end   = unit_tick && (phase_q == phase_len - 8'd1);
    assign last_pulse  = (num_q != 8'd0) && (pulse_cnt_q + 8'd1 == num_q);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            state_q   <= StIdle;
            pulse_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pulse_out <= pulse_out_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_ok) state_d = StPulse;
            end
            StPulse: begin
                if (abort)          state_d = StIdle;
                else if (phase_end) state_d = last_pulse ? StIdle : StGap;
            end
            StGap: begin
                if (abort)          state_d = StIdle;
                else if (phase_end) state_d = StPulse;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy        = (state_q != StIdle);
        done_d      = (state_q == StPulse) && (state_d == StIdle) && !abort;
        pulse_out_d = ~positive_q;
        if (state_d == StPulse) begin
            // On the start edge the polarity is not latched yet, so use the live input.
            pulse_out_d = (state_q == StIdle) ? cfg_positive : positive_q;
        end else if (state_d == StIdle) begin
            pulse_out_d = ~cfg_positive;
        end
    end

    // Prescaler and phase counters restart at every phase boundary.
    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            stage1_q    <= '0;
            decade_q    <= '0;
            phase_q     <= '0;
            pulse_cnt_q <= '0;
        end else begin
            if (state_q == StIdle || state_q != state_d) begin
                stage1_q <= '0;
                decade_q <= '0;
                phase_q  <= '0;
            end else if (stage1_wrap) begin
                stage1_q <= '0;
                if (unit_tick) begin
                    decade_q <= '0;
                    phase_q  <= phase_q + 8'd1;
                end else begin
                    decade_q <= decade_q + 24'd1;
                end
            end else begin
                stage1_q <= stage1_q + 5'd1;
            end

            if (state_q == StIdle) begin
                pulse_cnt_q <= '0;
            end else if (state_q == StPulse && phase_end && !abort) begin
                pulse_cnt_q <= pulse_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            positive_q   <= 1'b0;
            width_q      <= '0;
            gap_q        <= '0;
            num_q        <= '0;
            stage1_lim_q <= '0;
            decade_lim_q <= '0;
        end else if (state_q == StIdle && start_ok) begin
            positive_q   <= cfg_positive;
            width_q      <= (cfg_width == 8'd0) ? 8'd1 : cfg_width;
            gap_q        <= (cfg_gap == 8'd0) ? 8'd1 : cfg_gap;
            num_q        <= cfg_num_pulses;
            stage1_lim_q <= (cfg_stage1_count == 5'd0) ? 5'd1 : cfg_stage1_count;
            decade_lim_q <= decade_limit(cfg_time_base);
        end
    end

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen: expected values are queued at stimulus time and popped at checks.
module tb_pulse_gen;

    logic       clk = 1'b0;
    logic       rst_sync, start, abort, cfg_positive;
    logic [7:0] cfg_width, cfg_gap, cfg_num_pulses;
    logic [4:0] cfg_stage1_count;
    logic [2:0] cfg_time_base;
    logic       pulse_out, busy, done;
`ifdef PULSE_GEN_EXT_START_EN
    logic       ext_start;
`endif

    logic [31:0] exp_q[$];
    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pulse_gen dut (
        .clk             (clk),
        .rst_sync        (rst_sync),
        .start           (start),
        .abort           (abort),
        .cfg_positive    (cfg_positive),
        .cfg_width       (cfg_width),
        .cfg_gap         (cfg_gap),
        .cfg_num_pulses  (cfg_num_pulses),
        .cfg_stage1_count(cfg_stage1_count),
        .cfg_time_base   (cfg_time_base),
`ifdef PULSE_GEN_EXT_START_EN
        .ext_start       (ext_start),
`endif
        .pulse_out       (pulse_out),
        .busy            (busy),
        .done            (done)
    );

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %0d, nothing queued", tag, obs);
            return;
        end
        expv = exp_q.pop_front();
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic pos, input logic [7:0] w, input logic [7:0] g,
                           input logic [7:0] n, input logic [4:0] s, input logic [2:0] t);
        cfg_positive     = pos;
        cfg_width        = w;
        cfg_gap          = g;
        cfg_num_pulses   = n;
        cfg_stage1_count = s;
        cfg_time_base    = t;
    endtask

    initial begin
        int cnt;
        rst_sync = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
`ifdef PULSE_GEN_EXT_START_EN
        ext_start = 1'b0;
`endif
        set_cfg(1'b0, 8'd1, 8'd1, 8'd1, 5'd1, 3'd0);
        #12;
        push(0); push(0); push(0);
        check("reset_pulse_out", {31'd0, pulse_out});
        check("reset_busy", {31'd0, busy});
        check("reset_done", {31'd0, done});

        // Release with active-low polarity: idle level is high from the first edge.
        rst_sync = 1'b0;
        tick();
        push(1);
        check("idle_level_neg", {31'd0, pulse_out});
        cfg_positive = 1'b1;
        tick();
        push(0);
        check("idle_level_pos", {31'd0, pulse_out});

        // Basic train: W=3 G=2 N=2, T=1.
        set_cfg(1'b1, 8'd3, 8'd2, 8'd2, 5'd1, 3'd0);
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            push(((c >= 1 && c <= 3) || (c >= 6 && c <= 8)) ? 1 : 0);
            push((c <= 8) ? 1 : 0);
            if (c == 9) push(1);
        end
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
            check($sformatf("train_pulse_c%0d", c), {31'd0, pulse_out});
            check($sformatf("train_busy_c%0d", c), {31'd0, busy});
            if (c == 9) check("train_done", {31'd0, done});
        end
        tick();
        push(0);
        check("train_done_one_cycle", {31'd0, done});

        // Active-low, W=0 treated as 1, N=1.
        set_cfg(1'b0, 8'd0, 8'd5, 8'd1, 5'd1, 3'd0);
        tick();
        start = 1'b1;
        push(1);
        cnt = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
            if (pulse_out == 1'b0) cnt++;
        end
        check("neg_w0_low_cycles", cnt);

        // Prescaled pulse: S=4 tb=2 W=1 -> 400 clocks.
        set_cfg(1'b1, 8'd1, 8'd1, 8'd1, 5'd4, 3'd2);
        tick();
        start = 1'b1;
        push(400);
        cnt = 0;
        for (int c = 1; c <= 500; c++) begin
            tick();
            start = 1'b0;
            if (pulse_out == 1'b1) cnt++;
        end
        check("prescaled_width", cnt);

        // Continuous train aborted during the 4th pulse (cycles 13-14).
        set_cfg(1'b1, 8'd2, 8'd2, 8'd0, 5'd1, 3'd0);
        start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            start = 1'b0;
        end
        push(1);
        check("cont_4th_pulse_active", {31'd0, pulse_out});
        abort = 1'b1;
        tick();
        push(0); push(0); push(0);
        check("abort_pulse_out", {31'd0, pulse_out});
        check("abort_busy", {31'd0, busy});
        check("abort_done", {31'd0, done});
        abort = 1'b0;
        tick();
        push(0);
        check("abort_done_later", {31'd0, done});
        start = 1'b1;
        tick();
        start = 1'b0;
        push(1); push(1);
        check("restart_pulse_out", {31'd0, pulse_out});
        check("restart_busy", {31'd0, busy});
        abort = 1'b1;
        tick();
        start = 1'b1;
        tick();
        push(0);
        check("abort_beats_start", {31'd0, busy});
        abort = 1'b0;
        start = 1'b0;

        // Start coincident with done is ignored.
        set_cfg(1'b1, 8'd1, 8'd1, 8'd1, 5'd1, 3'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        push(1);
        check("single_done", {31'd0, done});
        start = 1'b1;
        tick();
        start = 1'b0;
        push(0);
        check("start_on_done_ignored", {31'd0, busy});

        // cfg changes while busy are ignored, then reset lands mid-gap.
        set_cfg(1'b1, 8'd2, 8'd3, 8'd0, 5'd1, 3'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_cfg(1'b0, 8'd10, 8'd1, 8'd1, 5'd2, 3'd1);
        push(1); push(1); push(0); push(0);
        check("latched_c1", {31'd0, pulse_out});
        tick();
        check("latched_c2", {31'd0, pulse_out});
        tick();
        check("latched_c3_gap", {31'd0, pulse_out});
        tick();
        check("latched_c4_gap", {31'd0, pulse_out});
        rst_sync = 1'b1;
        #1;
        push(0); push(0); push(0);
        check("midgap_reset_pulse_out", {31'd0, pulse_out});
        check("midgap_reset_busy", {31'd0, busy});
        check("midgap_reset_done", {31'd0, done});
        tick();
        rst_sync = 1'b0;
        tick();
        push(1); push(0);
        check("post_reset_idle_level", {31'd0, pulse_out});
        check("post_reset_no_done", {31'd0, done});

`ifdef PULSE_GEN_EXT_START_EN
        set_cfg(1'b1, 8'd1, 8'd1, 8'd1, 5'd1, 3'd0);
        ext_start = 1'b1;
        push(0); push(0); push(1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("ext_start_k%0d", c), {31'd0, pulse_out});
        end
        ext_start = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
